// File: rtl/quad_measure_ctrl_pkg.sv
// Shared types for the quadrature-oscillator measurement sequencer.
//   quad_state_e  : sequencer state encoding
//   MODE_*        : measurement mode encodings sampled with start
//   quad_result_t : captured result payload {count, cycles, timeout}
package quad_pkg;

  localparam int unsigned RES_COUNT_W  = 32;
  localparam int unsigned RES_CYCLES_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GATE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_HOLD   = 3'd4
  } quad_state_e;

  localparam logic MODE_WINDOW = 1'b0;
  localparam logic MODE_STOP   = 1'b1;

  typedef struct packed {
    logic [RES_COUNT_W-1:0]  count;
    logic [RES_CYCLES_W-1:0] cycles;
    logic                    timeout;
  } quad_result_t;

endpackage

// File: rtl/quad_down_timer.sv
// Loadable down-counter used for fixed dwell intervals.
//   load/load_val : load the counter (load wins over counting)
//   done          : registered flag, high while the count is zero
// Loading N holds done low for N cycles, so a dwell of D cycles loads D-1.
module quad_down_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q, count_d;
  logic         done_q, done_d;

  // Saturating decrement; done is precomputed from the next count.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
    done_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: rtl/quad_measure_ctrl.sv
// Sequencer for the quadrature-oscillator TDC counter: clear, gate, settle,
// capture, then present the result on a valid/ready port.
//   start/mode/window_len : measurement request (mode and length sampled with start)
//   stop                  : terminating event in stop mode
//   abort                 : cancel any measurement
//   osc_enable/osc_reset  : drive the oscillator counter
//   osc_count             : counter value captured at the end of settle
//   result_*              : captured count, gate length, timeout flag, handshake
//   busy                  : high in every state except idle
module quad_measure_ctrl
  import quad_pkg::*;
#(
  parameter int unsigned BIT_COUNT     = 32,
  parameter int unsigned WIN_W         = 16,
  parameter int unsigned CLEAR_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIN_W-1:0]     window_len,
  input  logic                 stop,
  input  logic                 abort,
  output logic                 osc_enable,
  output logic                 osc_reset,
  input  logic [BIT_COUNT-1:0] osc_count,
  input  logic                 osc_has_value,
  output logic [BIT_COUNT-1:0] result_count,
  output logic [WIN_W-1:0]     result_cycles,
  output logic                 result_timeout,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 busy
);

  quad_state_e  state_q, state_d;
  logic         mode_q, mode_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] gate_cnt_q, gate_cnt_d;
  logic         timeout_q, timeout_d;
  quad_result_t result_q, result_d;
  logic         osc_enable_q, osc_reset_q, result_valid_q, busy_q;

  logic             tmr_load_c;
  logic [WIN_W-1:0] tmr_val_c;
  logic             tmr_done;
  logic [WIN_W-1:0] gate_next_c;
  logic             abort_c;
  logic             gate_exit_c;

  // The end-of-window flag is informational only; capture happens regardless.
  logic unused_has_value;
  assign unused_has_value = osc_has_value;

  quad_down_timer #(.W(WIN_W)) u_dwell (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .done     (tmr_done)
  );

  // Next-state, datapath updates and dwell-timer control.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    win_d       = win_q;
    gate_cnt_d  = gate_cnt_q;
    timeout_d   = timeout_q;
    result_d    = result_q;
    tmr_load_c  = 1'b0;
    tmr_val_c   = '0;
    gate_exit_c = 1'b0;
    gate_next_c = gate_cnt_q + WIN_W'(1);
    abort_c     = abort && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d     = mode;
          win_d      = (window_len == '0) ? WIN_W'(1) : window_len;
          tmr_load_c = 1'b1;
          tmr_val_c  = WIN_W'(CLEAR_CYCLES - 1);
          state_d    = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (tmr_done) begin
          gate_cnt_d = '0;
          timeout_d  = 1'b0;
          state_d    = ST_GATE;
        end
      end
      ST_GATE: begin
        gate_cnt_d = gate_next_c;
        // stop beats a coincident timeout boundary
        if ((mode_q == MODE_STOP) && stop) begin
          gate_exit_c = 1'b1;
          timeout_d   = 1'b0;
        end else if (gate_next_c == win_q) begin
          gate_exit_c = 1'b1;
          timeout_d   = (mode_q == MODE_STOP);
        end
        if (gate_exit_c) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = WIN_W'(SETTLE_CYCLES - 1);
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_done && !abort_c) begin
          result_d.count   = RES_COUNT_W'(osc_count);
          result_d.cycles  = RES_CYCLES_W'(gate_cnt_q);
          result_d.timeout = timeout_q;
          state_d          = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_c) begin
      state_d = ST_IDLE;
    end
  end

  // Outputs are registered from the next state so they track state transitions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      mode_q         <= MODE_WINDOW;
      win_q          <= '0;
      gate_cnt_q     <= '0;
      timeout_q      <= 1'b0;
      result_q       <= '0;
      osc_enable_q   <= 1'b0;
      osc_reset_q    <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      win_q          <= win_d;
      gate_cnt_q     <= gate_cnt_d;
      timeout_q      <= timeout_d;
      result_q       <= result_d;
      osc_enable_q   <= (state_d == ST_GATE);
      osc_reset_q    <= (state_d == ST_CLEAR);
      result_valid_q <= (state_d == ST_HOLD);
      busy_q         <= (state_d != ST_IDLE);
    end
  end

  assign osc_enable     = osc_enable_q;
  assign osc_reset      = osc_reset_q;
  assign result_valid   = result_valid_q;
  assign busy           = busy_q;
  assign result_count   = BIT_COUNT'(result_q.count);
  assign result_cycles  = WIN_W'(result_q.cycles);
  assign result_timeout = result_q.timeout;

endmodule

// File: tb/tb_quad_measure_ctrl.sv
module tb_quad_measure_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, mode, stop, abort;
  logic [15:0] window_len;
  logic        osc_enable, osc_reset;
  logic [31:0] osc_count;
  logic        osc_has_value;
  logic [31:0] result_count;
  logic [15:0] result_cycles;
  logic        result_timeout, result_valid, result_ready, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  quad_measure_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .mode           (mode),
    .window_len     (window_len),
    .stop           (stop),
    .abort          (abort),
    .osc_enable     (osc_enable),
    .osc_reset      (osc_reset),
    .osc_count      (osc_count),
    .osc_has_value  (osc_has_value),
    .result_count   (result_count),
    .result_cycles  (result_cycles),
    .result_timeout (result_timeout),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .busy           (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and step until result_valid is seen. The bench's
  // counter model adds 3 per enabled cycle and clears while osc_reset is high.
  task automatic run_meas(input logic m, input logic [15:0] win, input int stop_at,
                          output int lat, output int en_n, output int rs_n,
                          output logic expired);
    int g;
    start = 1'b1; mode = m; window_len = win; osc_count = 32'd0;
    tick();
    start = 1'b0;
    lat = 1; en_n = 0; rs_n = 0; g = 0; expired = 1'b0;
    while (!result_valid) begin
      if (osc_reset) begin rs_n++; osc_count = 32'd0; end
      if (osc_enable) begin en_n++; g++; osc_count = osc_count + 32'd3; end
      stop = (stop_at != 0) && osc_enable && (g == stop_at);
      if (lat > 2000) begin expired = 1'b1; break; end
      tick();
      lat++;
    end
    stop = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 0; mode = 0; stop = 0; abort = 0; window_len = 0;
    osc_count = 32'h1234_5678; osc_has_value = 0; result_ready = 1;
    #23;
    total++; if (osc_enable !== 1'b0) begin bad++; $display("FAIL reset_osc_enable got=%b exp=0", osc_enable); end
    total++; if (osc_reset !== 1'b0) begin bad++; $display("FAIL reset_osc_reset got=%b exp=0", osc_reset); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (result_count !== 32'd0 || result_cycles !== 16'd0 || result_timeout !== 1'b0) begin
      bad++; $display("FAIL reset_result got=%h/%0d/%b exp=0/0/0", result_count, result_cycles, result_timeout);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_mode0();
    int lat, en_n, rs_n; logic exp_;
    result_ready = 1'b1;
    run_meas(1'b0, 16'd100, 0, lat, en_n, rs_n, exp_);
    total++; if (exp_) begin bad++; $display("FAIL m0_timeout_bound waited=%0d", lat); end
    total++; if (lat !== 113) begin bad++; $display("FAIL m0_latency got=%0d exp=113", lat); end
    total++; if (en_n !== 100) begin bad++; $display("FAIL m0_enable_cycles got=%0d exp=100", en_n); end
    total++; if (rs_n !== 4) begin bad++; $display("FAIL m0_reset_cycles got=%0d exp=4", rs_n); end
    total++; if (result_cycles !== 16'd100) begin bad++; $display("FAIL m0_cycles got=%0d exp=100", result_cycles); end
    total++; if (result_timeout !== 1'b0) begin bad++; $display("FAIL m0_timeout got=%b exp=0", result_timeout); end
    total++; if (result_count !== 32'd300) begin bad++; $display("FAIL m0_count got=%0d exp=300", result_count); end
    tick();
    total++; if (result_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL m0_after_handshake valid=%b busy=%b exp=0/0", result_valid, busy);
    end
  endtask

  task automatic test_stop();
    int lat, en_n, rs_n; logic exp_;
    run_meas(1'b1, 16'd50, 17, lat, en_n, rs_n, exp_);
    total++; if (exp_) begin bad++; $display("FAIL stop_bound waited=%0d", lat); end
    total++; if (result_cycles !== 16'd17) begin bad++; $display("FAIL stop_cycles got=%0d exp=17", result_cycles); end
    total++; if (result_timeout !== 1'b0) begin bad++; $display("FAIL stop_timeout got=%b exp=0", result_timeout); end
    total++; if (en_n !== 17) begin bad++; $display("FAIL stop_enable_cycles got=%0d exp=17", en_n); end
    total++; if (lat !== 30) begin bad++; $display("FAIL stop_latency got=%0d exp=30", lat); end
    tick();
  endtask

  task automatic test_timeout();
    int lat, en_n, rs_n; logic exp_;
    run_meas(1'b1, 16'd20, 0, lat, en_n, rs_n, exp_);
    total++; if (exp_) begin bad++; $display("FAIL to_bound waited=%0d", lat); end
    total++; if (result_cycles !== 16'd20) begin bad++; $display("FAIL to_cycles got=%0d exp=20", result_cycles); end
    total++; if (result_timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%b exp=1", result_timeout); end
    tick();
    run_meas(1'b1, 16'd20, 20, lat, en_n, rs_n, exp_);
    total++; if (exp_) begin bad++; $display("FAIL tie_bound waited=%0d", lat); end
    total++; if (result_cycles !== 16'd20) begin bad++; $display("FAIL tie_cycles got=%0d exp=20", result_cycles); end
    total++; if (result_timeout !== 1'b0) begin bad++; $display("FAIL tie_flag got=%b exp=0", result_timeout); end
    total++; if (lat !== 33) begin bad++; $display("FAIL tie_latency got=%0d exp=33", lat); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat, en_n, rs_n; logic exp_; int unstable;
    result_ready = 1'b0;
    run_meas(1'b0, 16'd5, 0, lat, en_n, rs_n, exp_);
    total++; if (exp_) begin bad++; $display("FAIL bp_bound waited=%0d", lat); end
    unstable = 0;
    for (int i = 0; i < 30; i++) begin
      start = ((i % 7) == 3);
      mode = 1'b1; window_len = 16'd9;
      tick();
      if (result_valid !== 1'b1 || result_count !== 32'd15 || result_cycles !== 16'd5 || busy !== 1'b1)
        unstable++;
    end
    start = 1'b0;
    total++; if (unstable !== 0) begin bad++; $display("FAIL bp_hold_stable bad_cycles=%0d exp=0 count=%0d cycles=%0d", unstable, result_count, result_cycles); end
    result_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (result_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_handshake valid=%b busy=%b exp=0/0", result_valid, busy);
    end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_start_ignored busy=%b exp=0", busy); end
  endtask

  task automatic test_abort();
    int n; int seen_valid;
    // abort during GATE
    start = 1'b1; mode = 1'b0; window_len = 16'd10;
    tick(); start = 1'b0;
    n = 0;
    while (!osc_enable && n < 50) begin tick(); n++; end
    tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    total++; if (osc_enable !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_gate enable=%b busy=%b exp=0/0", osc_enable, busy);
    end
    // abort during SETTLE
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!osc_enable && n < 50) begin tick(); n++; end
    while (osc_enable && n < 100) begin tick(); n++; end
    tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    total++; if (busy !== 1'b0 || result_valid !== 1'b0) begin
      bad++; $display("FAIL abort_settle busy=%b valid=%b exp=0/0", busy, result_valid);
    end
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (result_valid) seen_valid++; end
    total++; if (seen_valid !== 0) begin bad++; $display("FAIL abort_no_valid got=%0d exp=0", seen_valid); end
    total++; if (result_cycles !== 16'd5 || result_count !== 32'd15) begin
      bad++; $display("FAIL abort_result_kept cycles=%0d count=%0d exp=5/15", result_cycles, result_count);
    end
  endtask

  task automatic test_win0();
    int lat, en_n, rs_n; logic exp_;
    run_meas(1'b0, 16'd0, 0, lat, en_n, rs_n, exp_);
    total++; if (exp_) begin bad++; $display("FAIL w0_bound waited=%0d", lat); end
    total++; if (result_cycles !== 16'd1) begin bad++; $display("FAIL w0_cycles got=%0d exp=1", result_cycles); end
    total++; if (en_n !== 1) begin bad++; $display("FAIL w0_enable_cycles got=%0d exp=1", en_n); end
    total++; if (lat !== 14) begin bad++; $display("FAIL w0_latency got=%0d exp=14", lat); end
    tick();
  endtask

  task automatic test_reset_mid_gate();
    int n; int lat, en_n, rs_n; logic exp_;
    start = 1'b1; mode = 1'b0; window_len = 16'd40;
    tick(); start = 1'b0;
    n = 0;
    while (!osc_enable && n < 50) begin tick(); n++; end
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    total++; if (osc_enable !== 1'b0) begin bad++; $display("FAIL rst_gate_enable got=%b exp=0", osc_enable); end
    total++; if (busy !== 1'b0 || result_valid !== 1'b0 || osc_reset !== 1'b0) begin
      bad++; $display("FAIL rst_gate_ctrl busy=%b valid=%b oreset=%b exp=0/0/0", busy, result_valid, osc_reset);
    end
    total++; if (result_count !== 32'd0 || result_cycles !== 16'd0 || result_timeout !== 1'b0) begin
      bad++; $display("FAIL rst_gate_result got=%0d/%0d/%b exp=0/0/0", result_count, result_cycles, result_timeout);
    end
    #2 reset_n = 1'b1;
    tick();
    run_meas(1'b0, 16'd3, 0, lat, en_n, rs_n, exp_);
    total++; if (exp_) begin bad++; $display("FAIL rst_rerun_bound waited=%0d", lat); end
    total++; if (result_cycles !== 16'd3 || result_count !== 32'd9 || lat !== 16) begin
      bad++; $display("FAIL rst_rerun cycles=%0d count=%0d lat=%0d exp=3/9/16", result_cycles, result_count, lat);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_stop();
    test_timeout();
    test_backpressure();
    test_abort();
    test_win0();
    test_reset_mid_gate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quad_measure_ctrl.md
# quad_measure_ctrl

Sequencer for the quadrature-oscillator TDC counter. On each request it clears the oscillator counter, opens a gated enable window, waits for the counter to settle, and captures the binary count. It returns the count together with the gate length in `clk` cycles through a valid/ready result port. It sits between the DAQ control logic and the `OscillatorQuadrature` counter instance, and drives that instance's `enable` and `reset`.

## Interface
Parameters:
- BIT_COUNT, 32, width of the oscillator count
- WIN_W, 16, width of the window/timeout length and the gate-cycle counter
- CLEAR_CYCLES, 4, cycles `osc_reset` is held; must be ≥ 1 full quad-clock period
- SETTLE_CYCLES, 8, cycles waited after enable falls before capture; ≥ 2

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle measurement request
- mode  in  1  0 = fixed window, 1 = stop-terminated; sampled with `start`
- window_len  in  WIN_W  window length (mode 0) or timeout (mode 1); sampled with `start`
- stop  in  1  terminating event pulse (mode 1 only)
- abort  in  1  cancel any measurement
- osc_enable  out  1  to counter `enable`
- osc_reset  out  1  to counter `reset` (active-high)
- osc_count  in  BIT_COUNT  binary count from the counter
- osc_has_value  in  1  counter's end-of-window flag
- result_count  out  BIT_COUNT  captured count
- result_cycles  out  WIN_W  number of cycles `osc_enable` was high
- result_timeout  out  1  mode-1 window ended by timeout rather than `stop`
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, CLEAR, GATE, SETTLE, HOLD.
- IDLE, with `start`=1:
  - Latch `mode` and `window_len`; a `window_len` of 0 is treated as 1.
  - Next state CLEAR.
  - `start` in any other state is ignored.
- CLEAR:
  - `osc_reset`=1 for exactly CLEAR_CYCLES cycles, `osc_enable`=0.
  - Then GATE, with the gate counter cleared to 0.
- GATE:
  - `osc_enable`=1; the gate counter increments once per cycle.
  - Mode 0: leave GATE after exactly `window_len` cycles.
  - Mode 1: leave GATE on the cycle `stop`=1, which is counted. Also leave when the counter reaches `window_len`; that exit sets timeout=1.
  - `stop` and the timeout boundary in the same cycle: `stop` wins and timeout=0.
  - `stop` outside GATE, or in mode 0, is ignored.
- SETTLE:
  - `osc_enable`=0 for SETTLE_CYCLES cycles.
  - On the last cycle, capture `osc_count` into `result_count` and the gate counter into `result_cycles`.
  - If `osc_has_value`=0 at capture, the capture still occurs; nothing is flagged beyond the timeout bit.
  - Then HOLD.
- HOLD:
  - `result_valid`=1 and all result fields stable.
  - `result_valid` && `result_ready` → IDLE on the next cycle.
  - A new `start` arriving in the same cycle as that handshake is ignored.
- abort:
  - In any non-IDLE state, the next state is IDLE.
  - `osc_enable`, `osc_reset` and `result_valid` fall on the next edge.
  - Result registers keep their previous values.
  - `abort` takes priority over every other transition.
- Gate counter: WIN_W bits, cannot wrap, because the exit at `window_len` ≤ 2^WIN_W−1 occurs first.

## Timing
- Reset values:
  - State IDLE.
  - `osc_enable`, `osc_reset`, `result_valid`, `result_timeout`, `busy` = 0.
  - `result_count`, `result_cycles` = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Mode-0 latency:
  - `start` at edge T → `osc_reset` high over T+1 … T+CLEAR_CYCLES.
  - `osc_enable` high for `window_len` cycles.
  - `result_valid` rises CLEAR_CYCLES + `window_len` + SETTLE_CYCLES + 1 cycles after T.
- Mode-1 `stop` in GATE cycle k (1-based) → `osc_enable` is low starting at cycle k+1 and `result_cycles` = k.
- Assertion of `reset_n` at any point forces the reset values immediately (asynchronous). Deassertion is synchronized in the top level, not here.

## Structure
- Package `quad_pkg`:
  - `typedef enum logic [2:0]` for the state type (IDLE, CLEAR, GATE, SETTLE, HOLD).
  - Mode constants MODE_WINDOW=0 and MODE_STOP=1.
  - A packed struct `quad_result_t` holding {count, cycles, timeout}.
- One sub-module, `quad_down_timer`:
  - A loadable WIN_W-bit down-counter with a `done` flag.
  - Reused for the CLEAR and SETTLE dwell counts.
  - The gate counter stays an up-counter in the top module.
- The `OscillatorQuadrature` instance lives in the enclosing DAQ top, not inside this block.

## Test plan
- Reset mid-GATE:
  - Stimulus: `reset_n` low during GATE.
  - Response: `osc_enable`=0 the same instant; all outputs at reset values; the next `start` runs normally.
- Mode 0, `window_len`=100, `result_ready` held 1:
  - `osc_enable` high for exactly 100 cycles.
  - `result_cycles`=100, `result_timeout`=0.
  - `result_valid` high 1 cycle, at T+4+100+8+1.
- Mode 1, `window_len`=50, `stop` at GATE cycle 17: `result_cycles`=17, `result_timeout`=0.
- Mode 1 timeout and tie:
  - `window_len`=20, no `stop` → `result_cycles`=20, `result_timeout`=1.
  - `stop` exactly at cycle 20 → `result_timeout`=0.
- Backpressure: `result_ready`=0 for 30 cycles in HOLD, with `start` pulses during HOLD → result stable, pulses ignored, one handshake then IDLE.
- `abort` in SETTLE and `window_len`=0:
  - `abort` in SETTLE → IDLE next cycle, `result_valid` never rises.
  - `window_len`=0 in mode 0 → 1-cycle gate, `result_cycles`=1.
